// File: rtl/gpio_bus_arbiter.sv
// Two-master round-robin arbiter in front of the GPIO peripheral bus port.
// Each access occupies ISSUE (grant, strobe) then RESP (read capture); rvalid follows RESP.
module gpio_bus_arbiter #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_be_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [31:0]       m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_be_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [31:0]       m1_rdata_o,
  output logic              write_o,
  output logic [3:0]        data_be_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  input  logic [31:0]       rdata_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic                we_q, we_d;
  logic [3:0]          be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic [31:0]         rdata0_q, rdata0_d;
  logic [31:0]         rdata1_q, rdata1_d;
  logic                arb_any, arb_win, arb_en;

  // Under contention the master that did not win last time goes first.
  always_comb begin
    arb_any = m0_req_i | m1_req_i;
    if (m0_req_i && m1_req_i) arb_win = ~last_owner_q;
    else                      arb_win = m1_req_i;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rvalid_d     = '0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    m0_gnt_o     = 1'b0;
    m1_gnt_o     = 1'b0;
    write_o      = 1'b0;
    data_be_o    = '0;
    arb_en       = 1'b0;

    unique case (state_q)
      IDLE: arb_en = 1'b1;
      ISSUE: begin
        write_o   = we_q;
        data_be_o = be_q;
        m0_gnt_o  = ~owner_q;
        m1_gnt_o  = owner_q;
        state_d   = RESP;
      end
      RESP: begin
        data_be_o         = be_q;
        rvalid_d[owner_q] = 1'b1;
        if (!we_q) begin
          if (owner_q) rdata1_d = rdata_i;
          else         rdata0_d = rdata_i;
        end
        arb_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (arb_en && arb_any) begin
      state_d      = ISSUE;
      owner_d      = arb_win;
      last_owner_d = arb_win;
      we_d         = arb_win ? m1_we_i    : m0_we_i;
      be_d         = arb_win ? m1_be_i    : m0_be_i;
      addr_d       = arb_win ? m1_addr_i  : m0_addr_i;
      wdata_d      = arb_win ? m1_wdata_i : m0_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rvalid_q     <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rvalid_q     <= rvalid_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign m0_rvalid_o = rvalid_q[0];
  assign m1_rvalid_o = rvalid_q[1];
  assign m0_rdata_o  = rdata0_q;
  assign m1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Bench for gpio_bus_arbiter: event-schedule model, per-cycle compare, directed scenarios.
module tb_gpio_bus_arbiter;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [5:0]  addr;
    logic [31:0] wd;
  } cmd_t;

  typedef struct packed {
    logic        bus;
    logic        wr;
    logic [3:0]  be;
    logic [5:0]  addr;
    logic [31:0] wd;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic [1:0]  rdu;
    logic [31:0] rd_val;
  } slot_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_we_i, m0_gnt_o, m0_rvalid_o;
  logic [3:0]  m0_be_i;
  logic [5:0]  m0_addr_i;
  logic [31:0] m0_wdata_i, m0_rdata_o;
  logic        m1_req_i, m1_we_i, m1_gnt_o, m1_rvalid_o;
  logic [3:0]  m1_be_i;
  logic [5:0]  m1_addr_i;
  logic [31:0] m1_wdata_i, m1_rdata_o;
  logic        write_o;
  logic [3:0]  data_be_o;
  logic [5:0]  addr_o;
  logic [31:0] wdata_o, rdata_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  gpio_bus_arbiter #(.ADDR_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .write_o(write_o), .data_be_o(data_be_o), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_v(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h0000_A5A5 : {16'hC0DE, 16'(i)};
  endfunction

  function automatic cmd_t mk(input logic we, input logic [3:0] be, input logic [5:0] a, input logic [31:0] wd);
    cmd_t c;
    c.we = we; c.be = be; c.addr = a; c.wd = wd;
    return c;
  endfunction

  // Peripheral with registered read
  logic [31:0] mem [64];
  bit mem_ok = 1'b0;
  always @(posedge clk_i) begin
    if (!mem_ok) begin
      for (int i = 0; i < 64; i++) mem[i] = init_word(i);
      mem_ok = 1'b1;
    end
    rdata_i <= mem[addr_o];
    if (write_o)
      for (int b = 0; b < 4; b++)
        if (data_be_o[b]) mem[addr_o][8*b +: 8] = wdata_o[8*b +: 8];
  end

  // Master drivers: present head of queue, advance on grant
  cmd_t q0[$];
  cmd_t q1[$];

  initial begin : drv0
    m0_req_i = 1'b0; m0_we_i = 1'b0; m0_be_i = '0; m0_addr_i = '0; m0_wdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (m0_gnt_o && q0.size() > 0) q0.delete(0);
      if (q0.size() > 0) begin
        m0_req_i = 1'b1; m0_we_i = q0[0].we; m0_be_i = q0[0].be;
        m0_addr_i = q0[0].addr; m0_wdata_i = q0[0].wd;
      end else m0_req_i = 1'b0;
    end
  end

  initial begin : drv1
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_be_i = '0; m1_addr_i = '0; m1_wdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (m1_gnt_o && q1.size() > 0) q1.delete(0);
      if (q1.size() > 0) begin
        m1_req_i = 1'b1; m1_we_i = q1[0].we; m1_be_i = q1[0].be;
        m1_addr_i = q1[0].addr; m1_wdata_i = q1[0].wd;
      end else m1_req_i = 1'b0;
    end
  end

  // Model: an accepted request books its bus cycles and rvalid into future slots
  slot_t       ring [8];
  logic [31:0] shadow [64];
  bit          shadow_ok = 1'b0;
  bit          model_ok = 1'b0;
  int          next_arb = 0;
  int          last_owner = 1;
  logic [1:0]  e_gnt, e_rv;
  logic        e_wr;
  logic [3:0]  e_be;
  logic [5:0]  e_addr;
  logic [31:0] e_wd, e_rd0, e_rd1;

  always @(posedge clk_i) begin : model
    int s, w;
    cmd_t c;
    if (!shadow_ok) begin
      for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
      shadow_ok = 1'b1;
    end
    cyc++;
    if (rst_i) begin
      for (int i = 0; i < 8; i++) ring[i] = '0;
      next_arb = cyc + 1; last_owner = 1;
      e_gnt = '0; e_rv = '0; e_wr = 1'b0; e_be = '0; e_addr = '0; e_wd = '0; e_rd0 = '0; e_rd1 = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (cyc >= next_arb && (m0_req_i || m1_req_i)) begin
        if (m0_req_i && m1_req_i) w = 1 - last_owner;
        else                      w = m1_req_i ? 1 : 0;
        last_owner = w;
        if (w == 1) c = mk(m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i);
        else        c = mk(m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i);
        s = cyc % 8;
        ring[s].bus = 1'b1; ring[s].wr = c.we; ring[s].be = c.be;
        ring[s].addr = c.addr; ring[s].wd = c.wd; ring[s].gnt[w] = 1'b1;
        s = (cyc + 1) % 8;
        ring[s].bus = 1'b1; ring[s].wr = 1'b0; ring[s].be = c.be;
        ring[s].addr = c.addr; ring[s].wd = c.wd;
        s = (cyc + 2) % 8;
        ring[s].rv[w] = 1'b1;
        if (!c.we) begin
          ring[s].rdu[w] = 1'b1;
          ring[s].rd_val = shadow[c.addr];
        end else begin
          for (int b = 0; b < 4; b++)
            if (c.be[b]) shadow[c.addr][8*b +: 8] = c.wd[8*b +: 8];
        end
        next_arb = cyc + 2;
      end
      s = cyc % 8;
      e_gnt = ring[s].gnt;
      e_rv  = ring[s].rv;
      e_wr  = ring[s].bus & ring[s].wr;
      e_be  = ring[s].bus ? ring[s].be : 4'h0;
      if (ring[s].bus) begin
        e_addr = ring[s].addr;
        e_wd   = ring[s].wd;
      end
      if (ring[s].rdu[0]) e_rd0 = ring[s].rd_val;
      if (ring[s].rdu[1]) e_rd1 = ring[s].rd_val;
      ring[s] = '0;
    end
  end

  function automatic logic [127:0] dut_vec();
    return 128'({m1_gnt_o, m0_gnt_o, m1_rvalid_o, m0_rvalid_o, write_o, data_be_o,
                 addr_o, wdata_o, m1_rdata_o, m0_rdata_o});
  endfunction

  function automatic logic [127:0] exp_vec();
    return 128'({e_gnt[1], e_gnt[0], e_rv[1], e_rv[0], e_wr, e_be, e_addr, e_wd, e_rd1, e_rd0});
  endfunction

  // Event logs used by the directed checks
  int          g_cyc[$];
  int          g_m[$];
  int          v_cyc[$];
  int          v_m[$];
  logic [31:0] v_d[$];
  int          wr_cnt;
  logic [5:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_wd;

  always @(negedge clk_i) begin : compare
    if (model_ok) begin
      chk_v($sformatf("cyc%0d_outputs", cyc), dut_vec(), exp_vec());
      if (m0_gnt_o) begin g_cyc.push_back(cyc); g_m.push_back(0); end
      if (m1_gnt_o) begin g_cyc.push_back(cyc); g_m.push_back(1); end
      if (m0_rvalid_o) begin v_cyc.push_back(cyc); v_m.push_back(0); v_d.push_back(m0_rdata_o); end
      if (m1_rvalid_o) begin v_cyc.push_back(cyc); v_m.push_back(1); v_d.push_back(m1_rdata_o); end
      if (write_o) begin wr_cnt++; wr_addr = addr_o; wr_be = data_be_o; wr_wd = wdata_o; end
    end
  end

  task automatic start(output int t0);
    g_cyc.delete(); g_m.delete(); v_cyc.delete(); v_m.delete(); v_d.delete();
    wr_cnt = 0;
    @(posedge clk_i);
    #2;
    t0 = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk_i);
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL wait_done timeout actual=%0d required<%0d", n, budget);
    end
    repeat (4) @(negedge clk_i);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0, n;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk_v("reset_state", dut_vec(), '0);
    rst_i = 1'b0;

    start(t0);
    q0.push_back(mk(1'b0, 4'hF, 6'h04, 32'h0));
    wait_done(40);
    chk_i("rd_gnt_count", g_cyc.size(), 1);
    chk_i("rd_gnt_cycle", g_cyc[0], t0 + 1);
    chk_i("rd_gnt_master", g_m[0], 0);
    chk_i("rd_rvalid_cycle", v_cyc[0], t0 + 3);
    chk_v("rd_rdata", 128'(v_d[0]), 128'(32'h0000_A5A5));
    chk_i("rd_no_write", wr_cnt, 0);
    chk_v("rd_m1_rdata_quiet", 128'(m1_rdata_o), '0);

    start(t0);
    q1.push_back(mk(1'b1, 4'b0011, 6'h08, 32'h1234_5678));
    wait_done(40);
    chk_i("wr_strobe_count", wr_cnt, 1);
    chk_v("wr_addr", 128'(wr_addr), 128'(6'h08));
    chk_v("wr_be", 128'(wr_be), 128'(4'h3));
    chk_v("wr_wdata", 128'(wr_wd), 128'(32'h1234_5678));
    chk_i("wr_gnt_master", g_m[0], 1);
    chk_i("wr_rvalid_after_gnt", v_cyc[0] - g_cyc[0], 2);
    chk_v("wr_m1_rdata_unchanged", 128'(m1_rdata_o), '0);

    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    start(t0);
    q0.push_back(mk(1'b0, 4'hF, 6'h04, 32'h0));
    q1.push_back(mk(1'b0, 4'hF, 6'h08, 32'h0));
    wait_done(40);
    chk_i("cont_first_master", g_m[0], 0);
    chk_i("cont_first_gnt", g_cyc[0], t0 + 1);
    chk_i("cont_second_master", g_m[1], 1);
    chk_i("cont_second_gnt", g_cyc[1], t0 + 3);
    chk_i("cont_rvalid_spacing", v_cyc[1] - v_cyc[0], 2);
    chk_v("cont_m1_rdata", 128'(v_d[1]), 128'(32'hC0DE_5678));

    start(t0);
    for (int k = 0; k < 4; k++) begin
      q0.push_back(mk(1'b1, 4'hF, 6'(16 + k), 32'hA000_0000 + 32'(k)));
      q1.push_back(mk(1'b0, 4'hF, 6'(16 + k), 32'h0));
    end
    wait_done(80);
    chk_i("fair_gnt_count", g_cyc.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk_i($sformatf("fair_gnt%0d_master", i), g_m[i], i % 2);
      chk_i($sformatf("fair_gnt%0d_cycle", i), g_cyc[i], t0 + 1 + 2 * i);
    end
    for (int k = 0; k < 4; k++)
      chk_v($sformatf("fair_m1_rdata%0d", k), 128'(v_d[2*k+1]), 128'(32'hA000_0000 + 32'(k)));

    start(t0);
    q0.push_back(mk(1'b0, 4'hF, 6'h04, 32'h0));
    for (n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (m0_gnt_o) break;
    end
    chk_i("rst_wait_gnt", (n < 20) ? 1 : 0, 1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk_v("rst_resp_outputs", dut_vec(), '0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_i("rst_no_rvalid", v_cyc.size(), 0);
    start(t0);
    q1.push_back(mk(1'b0, 4'hF, 6'h04, 32'h0));
    wait_done(40);
    chk_i("rst_m1_gnt", g_cyc[0], t0 + 1);
    chk_i("rst_m1_rvalid", v_cyc[0], t0 + 3);
    chk_v("rst_m1_rdata", 128'(v_d[0]), 128'(32'h0000_A5A5));

    start(t0);
    q0.push_back(mk(1'b1, 4'hF, 6'h14, 32'h5A5A_0F0F));
    wait_done(40);
    repeat (5) begin
      @(negedge clk_i);
      chk_v("gap_strobe_be", 128'({write_o, data_be_o}), '0);
    end
    start(t0);
    q0.push_back(mk(1'b0, 4'hF, 6'h14, 32'h0));
    wait_done(40);
    chk_i("gap_gnt_cycle", g_cyc[0], t0 + 1);
    chk_i("gap_rvalid_cycle", v_cyc[0], t0 + 3);
    chk_v("gap_rdata", 128'(v_d[0]), 128'(32'h5A5A_0F0F));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_bus_arbiter.md
# gpio_bus_arbiter

Two-master arbiter that shares the single peripheral bus port of the GPIO peripheral (write strobe, byte enables, 6-bit address, 32-bit write/read data) between two requesters, e.g. the core's load/store unit (m0) and a debug/DMA engine (m1). It accepts request/grant transactions from each master, serialises them with round-robin fairness and presents one access at a time to the peripheral. It returns read data with a one-cycle valid pulse to the owning master. It sits between the bus decoder and the GPIO instance.

## Interface
- ADDR_W, 6, peripheral address width (word/byte addressing as seen by the peripheral, passed through unchanged)
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- mN_req_i  in  1  (N=0,1) access request; held high with command stable until gnt seen
- mN_we_i  in  1  1 = write, 0 = read
- mN_be_i  in  4  byte enables
- mN_addr_i  in  ADDR_W  address
- mN_wdata_i  in  32  write data
- mN_gnt_o  out  1  one-cycle pulse: command accepted
- mN_rvalid_o  out  1  one-cycle pulse: access complete (reads and writes)
- mN_rdata_o  out  32  read data, valid while rvalid_o high, held until next read completion for that master
- write_o  out  1  peripheral write strobe
- data_be_o  out  4  peripheral byte enables
- addr_o  out  ADDR_W  peripheral address
- wdata_o  out  32  peripheral write data
- rdata_i  in  32  peripheral read data, valid one cycle after addr_o is presented (registered read)

## Operation
- FSM states: IDLE, ISSUE, RESP. Command registers: owner (1 bit), we, be, addr, wdata. last_owner register.
- Arbitration (evaluated at the end of IDLE and at the end of RESP): only m0 requests -> m0; only m1 -> m1; both -> master != last_owner. Winner's command is latched, owner <= winner, last_owner <= winner, next state ISSUE. No request -> IDLE.
- ISSUE: addr_o/data_be_o/wdata_o driven from command registers; write_o = latched we; mOwner_gnt_o = 1. Next state RESP.
- RESP: addr_o/data_be_o/wdata_o held, write_o = 0. On a read, rdata_i is captured into mOwner_rdata_o; on a write, rdata_o is unchanged. mOwner_rvalid_o is set for the following cycle. Arbitration as above: next state ISSUE if any request is pending, else IDLE.
- A master drops req (or presents a new command) in the cycle after gnt. A request still high in RESP is treated as a new access.
- The non-owner's gnt_o and rvalid_o are always 0. The two gnt_o are never high simultaneously, nor are the two rvalid_o.
- Outside ISSUE/RESP: write_o = 0, data_be_o = 0, addr_o/wdata_o hold last values.

## Timing
- Reset values: state IDLE, last_owner = 1 (so m0 wins the first contention), owner = 0, all gnt_o/rvalid_o/write_o = 0, data_be_o = 0, addr_o = 0, wdata_o = 0, both rdata_o = 0.
- Latency: req sampled high at edge E (end of IDLE) -> ISSUE (gnt, write_o) in cycle E+1 -> RESP in E+2 -> rvalid/rdata in E+3.
- Throughput: back-to-back accesses every 2 cycles (RESP -> ISSUE directly); a single master with req continuously re-asserted gets one access per 2 cycles.
- Reset mid-transaction: rst_i high during ISSUE or RESP. The current cycle's outputs are unaffected (a write_o already in ISSUE still reaches the peripheral). At the next edge all state returns to reset values, and no rvalid_o is issued for the aborted access.
- Command inputs are sampled only at the arbitration edge. Changes while waiting for gnt are a master protocol violation, and the latched values prevail.

## Test plan
- Single read: m0 read addr 0x04 with the peripheral returning 0x0000_A5A5 -> m0_gnt_o in cycle 2, write_o = 0, m0_rvalid_o in cycle 4 with m0_rdata_o = 0x0000_A5A5; m1 outputs stay 0.
- Single write: m1 write addr 0x08, be 4'b0011, wdata 0x1234_5678 -> exactly one write_o pulse with addr_o 0x08, be 0x3, wdata 0x1234_5678; m1_rvalid_o 2 cycles after gnt; m1_rdata_o unchanged.
- Contention: m0 and m1 raise req in the same cycle after reset -> m0 granted first, m1 granted in the RESP cycle's successor (2 cycles later), m1_rvalid 2 cycles after m0_rvalid.
- Fairness: both masters hold req continuously for 8 accesses -> grants alternate m0,m1,m0,... with a 2-cycle spacing and no starvation.
- Reset in RESP: rst_i asserted during the RESP of an m0 read -> no m0_rvalid_o; all outputs at reset values the next cycle; a subsequent m1 request completes normally.
- Idle gap: request, then 5 idle cycles, then request -> FSM returns to IDLE, write_o/data_be_o stay 0 during the gap, and the second access latency is again 3 cycles to rvalid.
